// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: one-cycle load-use bubble, PC hold during branch/call/ret resolution.
// Outputs are Mealy (same cycle); stall counter and timeout flag are registered.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        id_branch,
    input  logic        id_call,
    input  logic        id_ret,
    input  logic        ex_MemRead,
    input  logic        ex_RegWrite,
    input  logic [3:0]  ex_reg_rd,
    input  logic        ctrl_resolve,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        PC_hazard,
    output logic        hazard_err,
    output logic [15:0] stall_count
);

    typedef enum logic {IDLE = 1'b0, CTRL_WAIT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_cnt_nxt;
    logic        r_hazard_err;
    logic        w_set_err;
    logic [15:0] r_stall_count;
    logic        w_load_use;
    logic        w_id_ctrl;

    assign w_load_use = ex_MemRead & ex_RegWrite & (ex_reg_rd != 4'd0) &
                        ((id_rs1_used & (id_rs1 == ex_reg_rd)) |
                         (id_rs2_used & (id_rs2 == ex_reg_rd)));
    assign w_id_ctrl  = id_branch | id_call | id_ret;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wait_cnt    <= 3'd0;
            r_hazard_err  <= 1'b0;
            r_stall_count <= 16'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_set_err)
                r_hazard_err <= 1'b1;
            if (pc_stall && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    // Load-use wins over a control instruction; the control entry simply waits for the bubble to clear.
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_set_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_load_use && w_id_ctrl) begin
                    w_next_state   = CTRL_WAIT;
                    w_wait_cnt_nxt = 3'd0;
                end
            end
            CTRL_WAIT: begin
                if (ctrl_resolve) begin
                    w_next_state = IDLE;
                end else if (r_wait_cnt == 3'd7) begin
                    w_set_err    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 3'd1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        PC_hazard   = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_load_use) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_id_ctrl) begin
                        pc_stall   = 1'b1;
                        ifid_flush = 1'b1;
                    end
                end
                CTRL_WAIT: begin
                    PC_hazard  = 1'b1;
                    ifid_flush = 1'b1;
                    pc_stall   = !ctrl_resolve;
                end
                default: ;
            endcase
        end
    end

    assign hazard_err  = r_hazard_err;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; expected outputs come from a cycle model and are scoreboarded per cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs1, id_rs2, ex_reg_rd;
    logic        id_rs1_used, id_rs2_used, id_branch, id_call, id_ret;
    logic        ex_MemRead, ex_RegWrite, ctrl_resolve;
    logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, hazard_err;
    logic [15:0] stall_count;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       call;
        logic       ret;
        logic       mr;
        logic       rw;
        logic [3:0] rd;
        logic       res;
    } stim_t;

    logic [21:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: in a control wait, how many wait cycles already elapsed, sticky error, stall total.
    bit m_wait = 0;
    int m_waited = 0;
    bit m_err = 0;
    int m_cnt = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_branch(id_branch), .id_call(id_call), .id_ret(id_ret),
        .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_reg_rd(ex_reg_rd),
        .ctrl_resolve(ctrl_resolve),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .PC_hazard(PC_hazard),
        .hazard_err(hazard_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bit lu, ctrl, st, ist, fl, bub, hz;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_rs1_used = s.u1; id_rs2_used = s.u2;
        id_branch = s.br; id_call = s.call; id_ret = s.ret;
        ex_MemRead = s.mr; ex_RegWrite = s.rw; ex_reg_rd = s.rd; ctrl_resolve = s.res;

        lu = s.mr && s.rw && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        ctrl = s.br || s.call || s.ret;
        {st, ist, fl, bub, hz} = '0;
        if (s.rst_n) begin
            if (m_wait) begin
                hz = 1; fl = 1; st = !s.res;
            end else if (lu) begin
                st = 1; ist = 1; bub = 1;
            end else if (ctrl) begin
                st = 1; fl = 1;
            end
        end
        exp_q.push_back({st, ist, fl, bub, hz, m_err, 16'(m_cnt)});

        if (!s.rst_n) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (st && m_cnt < 65535) m_cnt++;
            if (!m_wait) begin
                if (!lu && ctrl) begin
                    m_wait = 1; m_waited = 0;
                end
            end else if (s.res) begin
                m_wait = 0;
            end else if (m_waited == 7) begin
                m_err = 1; m_wait = 0;
            end else begin
                m_waited++;
            end
        end
        cyc++;
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation.
    initial begin
        logic [21:0] act, exp_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act = {pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, hazard_err, stall_count};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t got {stall,ifid_stall,flush,bubble,hazard,err,cnt}=%b%b%b%b%b%b,%h expected %b%b%b%b%b%b,%h",
                             $time, act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                             exp_v[21], exp_v[20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
                end
            end
        end
    end

    initial begin
        stim_t s;
        s = quiet();
        s.rst_n = 1'b0;
        rst_n = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_branch = 0; id_call = 0; id_ret = 0; ex_MemRead = 0; ex_RegWrite = 0;
        ex_reg_rd = 0; ctrl_resolve = 0;
        @(posedge clk);
        @(posedge clk);
        // Reset held with hazard-looking inputs: outputs must stay quiet.
        s.call = 1; s.mr = 1; s.rw = 1; s.rd = 4'd3; s.rs1 = 4'd3; s.u1 = 1;
        apply(s);
        apply(s);

        // Load-use on rs2, then same with rd=0.
        s = quiet(); s.mr = 1; s.rw = 1; s.rd = 4'd5; s.rs2 = 4'd5; s.u2 = 1;
        apply(s);
        s.rd = 4'd0; s.rs2 = 4'd0;
        apply(s);

        // Call resolving on the third wait cycle.
        s = quiet(); s.call = 1; apply(s);
        s = quiet(); apply(s); apply(s);
        s.res = 1; apply(s);
        s = quiet(); apply(s);

        // Load-use together with branch, then branch alone.
        s = quiet(); s.br = 1; s.mr = 1; s.rw = 1; s.rd = 4'd7; s.rs1 = 4'd7; s.u1 = 1;
        apply(s);
        s = quiet(); s.br = 1; apply(s);
        s = quiet(); s.res = 1; apply(s);
        s = quiet(); s.res = 1; apply(s);

        // Ret never resolved: timeout, sticky error.
        s = quiet(); s.ret = 1; apply(s);
        s = quiet();
        for (int i = 0; i < 12; i++) apply(s);

        // Reset on the second wait cycle.
        s = quiet(); s.call = 1; apply(s);
        s = quiet(); apply(s);
        s.rst_n = 0; apply(s);
        s = quiet(); apply(s); apply(s);

        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 63) != 0);
            s.rs1 = 4'($urandom_range(0, 3));
            s.rs2 = 4'($urandom_range(0, 3));
            s.u1 = 1'($urandom_range(0, 1));
            s.u2 = 1'($urandom_range(0, 1));
            s.br = ($urandom_range(0, 9) == 0);
            s.call = ($urandom_range(0, 11) == 0);
            s.ret = ($urandom_range(0, 11) == 0);
            s.mr = 1'($urandom_range(0, 1));
            s.rw = ($urandom_range(0, 3) != 0);
            s.rd = 4'($urandom_range(0, 3));
            s.res = ($urandom_range(0, 6) == 0);
            apply(s);
        end

        // Long load-use run to drive the counter into saturation.
        s = quiet(); s.rst_n = 0; apply(s);
        s = quiet(); s.mr = 1; s.rw = 1; s.rd = 4'd9; s.rs1 = 4'd9; s.u1 = 1;
        for (int i = 0; i < 65540; i++) apply(s);
        s = quiet();
        for (int i = 0; i < 4; i++) apply(s);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
